taylor_stage_1: RTL



---
 rtl/exp_pkg.sv | 28 ++
 rtl/range_cmp_sub.sv | 20 ++
 rtl/taylor_stage_1.sv | 100 ++++++++++
 3 files changed

// File: rtl/exp_pkg.sv
// Shared types and constants for the exponential datapath.
// fix_t is the 3.23 word passed between range reduction, Taylor stages and the final shifter.
package exp_pkg;

  localparam int FIX_W  = 26;
  localparam int FRAC_W = 23;
  localparam int K_W    = 4;
  localparam int STEP_W = 2;

  typedef logic [FIX_W-1:0]  fix_t;
  typedef logic [K_W-1:0]    k_t;
  typedef logic [STEP_W-1:0] step_t;

  // 0.693147 truncated to 23 fraction bits
  localparam fix_t LN2 = 26'h058B90C;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // ln2 scaled by 2^step, i.e. the subtrahend for one restoring step
  function automatic fix_t ln2_step(input step_t step);
    return LN2 << step;
  endfunction

endpackage

// File: rtl/range_cmp_sub.sv
// One restoring step: compare the residual against ln2 << step and
// subtract only when it fits, so the result never wraps.
import exp_pkg::*;

module range_cmp_sub (
  input  fix_t  res,
  input  step_t step,
  output fix_t  diff,
  output logic  take
);

  fix_t sub_c;

  always_comb begin
    sub_c = ln2_step(step);
    take  = (res >= sub_c);
    diff  = take ? (res - sub_c) : res;
  end

endmodule

// File: rtl/taylor_stage_1.sv
// Range reduction X = K*ln2 + R, one restoring subtract per cycle for
// bits K[3]..K[0], with valid/ready handshakes on both sides.
import exp_pkg::*;

module taylor_stage_1 (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [FIX_W-1:0] IN_X,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [FIX_W-1:0] OUT_R,
  output logic [K_W-1:0]   OUT_K
);

  state_e state_q, state_d;
  fix_t   res_q, res_d;
  k_t     k_q, k_d;
  step_t  step_q, step_d;
  logic   out_valid_q, out_valid_d;
  fix_t   out_r_q, out_r_d;
  k_t     out_k_q, out_k_d;

  fix_t   cmp_diff;
  logic   cmp_take;

  range_cmp_sub u_cmp (
    .res  (res_q),
    .step (step_q),
    .diff (cmp_diff),
    .take (cmp_take)
  );

  always_comb begin
    state_d     = state_q;
    res_d       = res_q;
    k_d         = k_q;
    step_d      = step_q;
    out_valid_d = out_valid_q;
    out_r_d     = out_r_q;
    out_k_d     = out_k_q;
    case (state_q)
      IDLE: begin
        if (IN_VALID) begin
          res_d   = IN_X;
          k_d     = '0;
          step_d  = step_t'(STEP_W'(3));
          state_d = RUN;
        end
      end
      RUN: begin
        res_d = cmp_diff;
        if (cmp_take) k_d[step_q] = 1'b1;
        if (step_q == '0) begin
          // Outputs are captured here so they stay put through DONE and after
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_r_d     = cmp_diff;
          out_k_d     = k_d;
        end else begin
          step_d = step_q - step_t'(1);
        end
      end
      DONE: begin
        if (OUT_READY) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      res_q       <= '0;
      k_q         <= '0;
      step_q      <= '0;
      out_valid_q <= 1'b0;
      out_r_q     <= '0;
      out_k_q     <= '0;
    end else begin
      state_q     <= state_d;
      res_q       <= res_d;
      k_q         <= k_d;
      step_q      <= step_d;
      out_valid_q <= out_valid_d;
      out_r_q     <= out_r_d;
      out_k_q     <= out_k_d;
    end
  end

  assign IN_READY  = (state_q == IDLE) && !RST;
  assign OUT_VALID = out_valid_q;
  assign OUT_R     = out_r_q;
  assign OUT_K     = out_k_q;

endmodule
